// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, row sync, press/release debounce, one-strobe-per-press key code
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 27000,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int STROBE_CYCLES   = 2
) (
    input  logic       clk_27mhz,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [7:0] key_code_raw,
    output logic       key_pressed
);
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(STROBE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] STB_LAST  = TW'(STROBE_CYCLES - 1);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, WAIT_RELEASE} state_t;
    state_t state, state_nx;
    logic [3:0] sync1, rows_s, row_lat, lat_nx, col_nx, col_rot;
    logic [SW-1:0] scan_cnt, scan_nx;
    logic [DW-1:0] deb_cnt, deb_nx;
    logic [TW-1:0] stb_cnt, stb_nx;
    logic [7:0] code_nx;
    logic one_low;
    assign col_rot     = {col_n[2:0], col_n[3]};
    assign one_low     = $onehot(~rows_s);
    assign key_valid   = state == REPORT;
    assign key_pressed = state == REPORT || state == WAIT_RELEASE;
    always_ff @(posedge clk_27mhz) begin
        if (reset) begin
            sync1        <= 4'hF;
            rows_s       <= 4'hF;
            state        <= SCAN;
            col_n        <= 4'b1110;
            scan_cnt     <= '0;
            deb_cnt      <= '0;
            stb_cnt      <= '0;
            row_lat      <= 4'hF;
            key_code_raw <= 8'hFF;
        end else begin
            sync1        <= row_n;
            rows_s       <= sync1;
            state        <= state_nx;
            col_n        <= col_nx;
            scan_cnt     <= scan_nx;
            deb_cnt      <= deb_nx;
            stb_cnt      <= stb_nx;
            row_lat      <= lat_nx;
            key_code_raw <= code_nx;
        end
    end
    always_comb begin
        state_nx = state;
        col_nx   = col_n;
        scan_nx  = scan_cnt;
        deb_nx   = deb_cnt;
        stb_nx   = stb_cnt;
        lat_nx   = row_lat;
        code_nx  = key_code_raw;
        case (state)
            SCAN: begin
                if (scan_cnt != SCAN_LAST) begin
                    scan_nx = scan_cnt + 1'b1;
                end else if (one_low) begin
                    lat_nx   = rows_s;
                    deb_nx   = '0;
                    state_nx = DEBOUNCE;
                end else begin
                    col_nx  = col_rot;
                    scan_nx = '0;
                end
            end
            DEBOUNCE: begin
                if (rows_s != row_lat) begin
                    state_nx = SCAN;
                    col_nx   = col_rot;
                    scan_nx  = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = REPORT;
                    code_nx  = {col_n, row_lat};
                    stb_nx   = '0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            REPORT: begin
                if (stb_cnt == STB_LAST) begin
                    state_nx = WAIT_RELEASE;
                    deb_nx   = '0;
                end else begin
                    stb_nx = stb_cnt + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                // any non-idle row sample restarts the release window
                if (rows_s != 4'hF) begin
                    deb_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = SCAN;
                    col_nx   = col_rot;
                    scan_nx  = '0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            default: state_nx = SCAN;
        endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with per-cycle hand-derived expectations
module tb_keypad_scanner;
    logic       clk_27mhz = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [7:0] key_code_raw;
    logic       key_pressed;
    logic [15:0] keys = '0;
    int checks = 0;
    int failures = 0;
    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .STROBE_CYCLES(2)) dut (
        .clk_27mhz(clk_27mhz),
        .reset(reset),
        .row_n(row_n),
        .col_n(col_n),
        .key_valid(key_valid),
        .key_code_raw(key_code_raw),
        .key_pressed(key_pressed)
    );
    always #5 clk_27mhz = ~clk_27mhz;
    // key (c,r) is keys[c*4+r]; it pulls row r low while column c is driven low
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
    end
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic chk_cycle(input string tag, input int n, input logic [3:0] ec, input logic ev,
                             input logic ep, input logic [7:0] ek);
        check($sformatf("%s n=%0d col_n", tag, n), 8'(col_n), 8'(ec));
        check($sformatf("%s n=%0d key_valid", tag, n), 8'(key_valid), 8'(ev));
        check($sformatf("%s n=%0d key_pressed", tag, n), 8'(key_pressed), 8'(ep));
        check($sformatf("%s n=%0d key_code_raw", tag, n), key_code_raw, ek);
    endtask
    function automatic logic [3:0] idle_col(input int n);
        logic [3:0] one = 4'b0001;
        return ~(one << ((n / 4) % 4));
    endfunction
    task automatic do_reset();
        reset = 1'b1;
        keys = '0;
        repeat (3) @(posedge clk_27mhz);
        @(negedge clk_27mhz);
        reset = 1'b0;
    endtask
    initial begin
        do_reset();
        chk_cycle("reset", 0, 4'b1110, 1'b0, 1'b0, 8'hFF);
        for (int n = 0; n < 20; n++) begin
            chk_cycle("idle", n, idle_col(n), 1'b0, 1'b0, 8'hFF);
            @(negedge clk_27mhz);
        end
        // held press of (2,1), glitchy release, then press of (3,3)
        do_reset();
        for (int n = 0; n < 63; n++) begin
            keys[9] = (n < 30) || (n == 34);
            keys[15] = n >= 45;
            chk_cycle("press", n, n < 8 ? idle_col(n) : (n < 45 ? 4'b1011 : 4'b0111),
                      n == 20 || n == 21 || n == 57 || n == 58,
                      (n >= 20 && n < 45) || n >= 57,
                      n < 20 ? 8'hFF : (n < 57 ? 8'b1011_1101 : 8'b0111_0111));
            @(negedge clk_27mhz);
        end
        // press of (2,1) released during debounce
        do_reset();
        for (int n = 0; n < 26; n++) begin
            keys[9] = n < 15;
            chk_cycle("bounce", n,
                      n < 8 ? idle_col(n) : (n < 18 ? 4'b1011 : (n < 22 ? 4'b0111 : 4'b1110)),
                      1'b0, 1'b0, 8'hFF);
            @(negedge clk_27mhz);
        end
        // two keys in column 0: ghosting, never debounced
        do_reset();
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        for (int n = 0; n < 24; n++) begin
            chk_cycle("ghost", n, idle_col(n), 1'b0, 1'b0, 8'hFF);
            @(negedge clk_27mhz);
        end
        // reset in the middle of debouncing (2,1)
        do_reset();
        keys[9] = 1'b1;
        for (int n = 0; n < 16; n++) begin
            chk_cycle("pre_rst", n, n < 8 ? idle_col(n) : 4'b1011, 1'b0, 1'b0, 8'hFF);
            if (n < 15) @(negedge clk_27mhz);
        end
        reset = 1'b1;
        keys = '0;
        @(negedge clk_27mhz);
        chk_cycle("mid_rst", 0, 4'b1110, 1'b0, 1'b0, 8'hFF);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            chk_cycle("post_rst", n, idle_col(n), 1'b0, 1'b0, 8'hFF);
            @(negedge clk_27mhz);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
